// File: rtl/switch_debouncer_pkg.sv
// Shared defaults, width helpers and per-bit action encoding for switch_debouncer.
package switch_debouncer_pkg;

  localparam int unsigned DEF_OUTPUT_WIDTH   = 3;
  localparam int unsigned DEF_TICK_DIV       = 16;
  localparam int unsigned DEF_STABLE_SAMPLES = 4;

  typedef enum logic [1:0] {
    BIT_HOLD,
    BIT_CLEAR,
    BIT_COUNT,
    BIT_ACCEPT
  } bit_action_e;

  function automatic int unsigned req_width(input int unsigned out_width);
    return 1 << out_width;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// One raw line: 2-flop synchroniser, tick-sampled stability counter, registered level.
module debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter  int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  localparam int unsigned CW             = cnt_width(STABLE_SAMPLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic raw_i,
  output logic out_o,
  output logic upd_o
);

  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

  logic          meta_q;
  logic          sync_q;
  logic          out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  bit_action_e   act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  // Any agreeing sample clears progress, so only an unbroken run is accepted.
  always_comb begin
    act = BIT_HOLD;
    if (tick_i) begin
      if (sync_q == out_q) begin
        act = BIT_CLEAR;
      end else if (cnt_q == CNT_LAST) begin
        act = BIT_ACCEPT;
      end else begin
        act = BIT_COUNT;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    unique case (act)
      BIT_CLEAR:  cnt_d = '0;
      BIT_COUNT:  cnt_d = cnt_q + 1'b1;
      BIT_ACCEPT: begin
        cnt_d = '0;
        out_d = sync_q;
      end
      default: ;
    endcase
  end

  assign out_o = out_q;
  assign upd_o = (act == BIT_ACCEPT);

endmodule

// File: rtl/switch_debouncer.sv
// Debounces W request switches plus an enable switch for the priority encoder.
// Define SWITCH_DEBOUNCER_EDGE_EN to add the per-bit rise pulse port.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter  int unsigned OUTPUT_WIDTH   = DEF_OUTPUT_WIDTH,
  parameter  int unsigned TICK_DIV       = DEF_TICK_DIV,
  parameter  int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  localparam int unsigned W              = req_width(OUTPUT_WIDTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sw_raw,
  input  logic         en_raw,
  output logic [W-1:0] sw_out,
  output logic         en_out,
  output logic         changed
`ifdef SWITCH_DEBOUNCER_EDGE_EN
  ,
  output logic [W-1:0] rise
`endif
);

  localparam int unsigned   PW      = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PC_LAST = PW'(TICK_DIV - 1);

  if (TICK_DIV == 0) begin : g_bad_tick_div
    $error("switch_debouncer: TICK_DIV must be >= 1");
  end
  if (STABLE_SAMPLES == 0) begin : g_bad_stable_samples
    $error("switch_debouncer: STABLE_SAMPLES must be >= 1");
  end

  logic [PW-1:0] pc_q, pc_d;
  logic          tick;
  logic [W:0]    raw_all;
  logic [W:0]    out_all;
  logic [W:0]    upd_all;
  logic          changed_q;

  assign tick = (pc_q == PC_LAST);
  assign pc_d = tick ? '0 : pc_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Enable rides as the top line so it shares the same conditioning path.
  assign raw_all = {en_raw, sw_raw};

  for (genvar i = 0; i <= W; i++) begin : g_line
    debounce_bit #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .tick_i(tick),
      .raw_i (raw_all[i]),
      .out_o (out_all[i]),
      .upd_o (upd_all[i])
    );
  end

  assign sw_out = out_all[W-1:0];
  assign en_out = out_all[W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= |upd_all;
    end
  end

  assign changed = changed_q;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
  logic [W-1:0] rise_q;

  // A bit that updates while currently 0 is necessarily going to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
    end else begin
      rise_q <= upd_all[W-1:0] & ~out_all[W-1:0];
    end
  end

  assign rise = rise_q;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: directed corners, vector table, random vs model.
module tb_switch_debouncer;

  localparam int OW = 3;
  localparam int TD = 4;
  localparam int SS = 3;
  localparam int W  = 1 << OW;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sw_raw;
  logic         en_raw;
  logic [W-1:0] sw_out;
  logic         en_out;
  logic         changed;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
  logic [W-1:0] rise;
`endif

  int unsigned  checks;
  int unsigned  errors;
  int unsigned  pulses;
  logic [W-1:0] rise_acc;

  switch_debouncer #(
    .OUTPUT_WIDTH  (OW),
    .TICK_DIV      (TD),
    .STABLE_SAMPLES(SS)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_raw (sw_raw),
    .en_raw (en_raw),
    .sw_out (sw_out),
    .en_out (en_out),
    .changed(changed)
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    ,
    .rise   (rise)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a line accepts the opposite level once its last SS
  // tick-time samples all disagree with the current output.
  logic [W:0]   m_s1, m_s2, m_out;
  logic [W:0]   m_hist [SS];
  int unsigned  m_edges;
  logic         m_changed;
  logic [W-1:0] m_rise;

  function automatic logic [W:0] flip_mask(input logic [W:0] cur, input logic [W:0] newest);
    logic [W:0] f;
    logic       agree;
    f = '0;
    for (int i = 0; i <= W; i++) begin
      agree = (newest[i] == cur[i]);
      for (int k = 0; k < SS - 1; k++) begin
        if (m_hist[k][i] == cur[i]) agree = 1'b1;
      end
      f[i] = !agree;
    end
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1      <= '0;
      m_s2      <= '0;
      m_out     <= '0;
      m_edges   <= 0;
      m_changed <= 1'b0;
      m_rise    <= '0;
      for (int k = 0; k < SS; k++) m_hist[k] <= '0;
    end else begin
      m_edges   <= m_edges + 1;
      m_s1      <= {en_raw, sw_raw};
      m_s2      <= m_s1;
      m_changed <= 1'b0;
      m_rise    <= '0;
      if ((m_edges + 1) % TD == 0) begin
        for (int k = SS - 1; k > 0; k--) m_hist[k] <= m_hist[k-1];
        m_hist[0] <= m_s2;
        m_out     <= m_out ^ flip_mask(m_out, m_s2);
        m_changed <= |flip_mask(m_out, m_s2);
        m_rise    <= flip_mask(m_out, m_s2)[W-1:0] & ~m_out[W-1:0];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (changed) pulses++;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    rise_acc |= rise;
`endif
  endtask

  // Steps until the masked outputs match; lat stays 0 if the limit expires.
  task automatic wait_for(input logic [W:0] mask, input logic [W:0] val,
                          input int unsigned limit, output int unsigned lat);
    lat = 0;
    for (int unsigned k = 1; k <= limit; k++) begin
      step();
      if ((({en_out, sw_out}) & mask) == val) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [W-1:0] sw;
    logic         en;
    logic [W-1:0] exp_sw;
    logic         exp_en;
    int unsigned  exp_pulses;
    logic [W-1:0] exp_rise;
  } vec_t;

  vec_t        vecs [7];
  int unsigned lat;
  int unsigned hold;
  logic        val;

  initial begin
    checks   = 0;
    errors   = 0;
    pulses   = 0;
    rise_acc = '0;

    vecs[0] = '{8'h24, 1'b1, 8'h24, 1'b1, 1, 8'h24};
    vecs[1] = '{8'h24, 1'b0, 8'h24, 1'b0, 1, 8'h00};
    vecs[2] = '{8'h81, 1'b0, 8'h81, 1'b0, 1, 8'h81};
    vecs[3] = '{8'h81, 1'b0, 8'h81, 1'b0, 0, 8'h00};
    vecs[4] = '{8'h00, 1'b1, 8'h00, 1'b1, 1, 8'h00};
    vecs[5] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1, 8'hFF};
    vecs[6] = '{8'h7E, 1'b0, 8'h7E, 1'b0, 1, 8'h00};

    // Reset holds everything low even with inputs high.
    rst_n  = 1'b0;
    sw_raw = 8'hFF;
    en_raw = 1'b1;
    repeat (3) step();
    check("rst_sw_out", sw_out, 0);
    check("rst_en_out", en_out, 0);
    check("rst_changed", changed, 0);
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    check("rst_rise", rise, 0);
`endif
    rst_n  = 1'b1;
    pulses = 0;
    wait_for({1'b1, 8'hFF}, {1'b1, 8'hFF}, 20, lat);
    check("rst_release_seen", lat != 0, 1);
    check("rst_release_le14", lat <= 14, 1);
    repeat (4) step();
    check("rst_release_pulses", pulses, 1);

    // Clean step 00 -> 24.
    sw_raw = '0;
    en_raw = 1'b0;
    do_reset();
    repeat (5) step();
    pulses   = 0;
    rise_acc = '0;
    sw_raw   = 8'h24;
    wait_for({1'b0, 8'hFF}, {1'b0, 8'h24}, 20, lat);
    check("step_lat_ge11", lat >= 11, 1);
    check("step_lat_le14", lat <= 14, 1);
    repeat (4) step();
    check("step_pulses", pulses, 1);
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    check("step_rise", rise_acc, 8'h24);
`endif

    // Glitch on bit 5 is rejected.
    sw_raw = '0;
    repeat (16) step();
    pulses = 0;
    sw_raw = 8'h20;
    repeat (6) step();
    sw_raw = 8'h00;
    repeat (20) step();
    check("glitch_sw_out", sw_out, 0);
    check("glitch_pulses", pulses, 0);

    // Bounce on bit 0, then settle high.
    val    = 1'b0;
    pulses = 0;
    for (int t = 0; t < 6; t++) begin
      val       = ~val;
      sw_raw[0] = val;
      repeat (3) step();
    end
    check("bounce_still_low", sw_out[0], 0);
    sw_raw[0] = 1'b1;
    wait_for({1'b0, 8'h01}, {1'b0, 8'h01}, 20, lat);
    check("bounce_lat_ge11", lat >= 11, 1);
    check("bounce_lat_le14", lat <= 14, 1);
    repeat (4) step();
    check("bounce_pulses", pulses, 1);

    // Enable and bit 7 together.
    pulses = 0;
    sw_raw = 8'h81;
    en_raw = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (en_out || sw_out[7]) break;
    end
    check("simul_both", {en_out, sw_out[7]}, 2'b11);
    repeat (4) step();
    check("simul_pulses", pulses, 1);

    // Vector table, each entry held long enough to settle.
    for (int v = 0; v < 7; v++) begin
      pulses   = 0;
      rise_acc = '0;
      sw_raw   = vecs[v].sw;
      en_raw   = vecs[v].en;
      repeat (16) step();
      check($sformatf("vec%0d_sw", v), sw_out, vecs[v].exp_sw);
      check($sformatf("vec%0d_en", v), en_out, vecs[v].exp_en);
      check($sformatf("vec%0d_pulses", v), pulses, vecs[v].exp_pulses);
`ifdef SWITCH_DEBOUNCER_EDGE_EN
      check($sformatf("vec%0d_rise", v), rise_acc, vecs[v].exp_rise);
`endif
    end

    // Reset after two qualifying ticks discards progress.
    sw_raw = '0;
    en_raw = 1'b0;
    do_reset();
    sw_raw = 8'h24;
    repeat (9) step();
    check("midcnt_pre", sw_out, 0);
    rst_n = 1'b0;
    step();
    check("midcnt_in_rst", sw_out, 0);
    step();
    rst_n = 1'b1;
    wait_for({1'b0, 8'hFF}, {1'b0, 8'h24}, 20, lat);
    check("midcnt_lat_ge12", lat >= 12, 1);
    check("midcnt_lat_le14", lat <= 14, 1);

    // Random stimulus against the model.
    sw_raw = '0;
    en_raw = 1'b0;
    do_reset();
    hold = 0;
    for (int n = 0; n < 1200; n++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 1) == 0) sw_raw = W'($urandom);
        else sw_raw[$urandom_range(0, W - 1)] ^= 1'b1;
        if ($urandom_range(0, 4) == 0) en_raw = ~en_raw;
        hold = $urandom_range(1, 14);
      end
      hold--;
      @(negedge clk);
      check("rnd_sw", sw_out, m_out[W-1:0]);
      check("rnd_en", en_out, m_out[W]);
      check("rnd_changed", changed, m_changed);
`ifdef SWITCH_DEBOUNCER_EDGE_EN
      check("rnd_rise", rise, m_rise);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
